dec_sel_sequencer: RTL and testbench
====================================

DEC_SEL_SEQUENCER -- requirements
Module: dec_sel_sequencer

Interface
REQ-001 SHALL have parameter DW, default 4, width of dwell field.
REQ-002 SHALL have parameter NW, default 4, width of period-count field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  run request, sampled at rising clk edge.
REQ-006 SHALL have port stop  input  1  abort request, sampled at rising clk edge.
REQ-007 SHALL have port dwell  input  DW  cycles per phase minus one.
REQ-008 SHALL have port periods  input  NW  number of full 0/1 periods minus one.
REQ-009 SHALL have port dec_y  input  2  one-hot feedback from downstream 1-to-2 decoder outputs.
REQ-010 SHALL have port sel  output  1  registered select driving the 1-to-2 decoder input.
REQ-011 SHALL have port busy  output  1  high while in SEL0 or SEL1.
REQ-012 SHALL have port done  output  1  single-cycle completion pulse.
REQ-013 SHALL have port err  output  1  sticky decoder-feedback mismatch flag.

Function
REQ-014 SHALL implement FSM states IDLE, SEL0, SEL1, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with start=1 and stop=0, latch dwell and periods, clear err, and enter SEL0 next cycle.
REQ-016 SHALL ignore dwell/periods changes after latching until the next accepted start.
REQ-017 SHALL drive sel=0 in SEL0 and sel=1 in SEL1; sel=0 in IDLE and DONE.
REQ-018 SHALL hold each of SEL0 and SEL1 for exactly latched dwell+1 cycles (dwell=0 -> 1 cycle), using a down-counter reloaded on each phase entry.
REQ-019 SHALL go SEL0 -> SEL1 at phase end; at SEL1 end go SEL0 if periods remaining > 0 (decrement), else DONE.
REQ-020 SHALL produce total busy time of 2*(dwell+1)*(periods+1) cycles.
REQ-021 SHALL assert done for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-022 SHALL ignore start while busy or in DONE.
REQ-023 SHALL, on stop=1 in SEL0 or SEL1, enter IDLE next cycle with sel=0, busy=0, no done pulse; err retained.
REQ-024 SHALL ignore stop in DONE; in IDLE with start=1 and stop=1 same cycle, stop wins and FSM stays IDLE.
REQ-025 SHALL, in SEL0/SEL1 each cycle, compare dec_y to expected one-hot (sel=0 -> 2'b01, sel=1 -> 2'b10) and set err at next edge on mismatch.
REQ-026 SHALL not check dec_y in IDLE or DONE.
REQ-027 SHALL keep err set until reset or the next accepted start.

Reset
REQ-028 SHALL, on rst=1, immediately (without clk) force IDLE, sel=0, busy=0, done=0, err=0, counters=0.
REQ-029 SHALL, on rst asserted mid-run, abandon the run with no done pulse; operation resumes only via a new start after rst deasserts.

Verification
REQ-030 SHALL cover: rst pulse with no clk -> sel=0, busy=0, done=0, err=0 immediately.
REQ-031 SHALL cover: dwell=2, periods=1, start 1 cycle -> sel 0,0,0,1,1,1,0,0,0,1,1,1 (busy 12 cycles), done=1 on cycle 13, then IDLE.
REQ-032 SHALL cover: dwell=0, periods=0 -> sel 0 then 1, done on 3rd cycle; start during busy has no effect; start+stop together in IDLE -> stays IDLE.
REQ-033 SHALL cover: stop asserted in 2nd SEL1 cycle (dwell=3) -> next cycle busy=0, sel=0, done never pulses.
REQ-034 SHALL cover: dec_y=2'b11 for one SEL1 cycle -> err=1 next cycle, held through done; next accepted start clears err=0.
REQ-035 SHALL cover: rst asserted between edges mid-SEL0 -> outputs zero before next edge; fresh start after release runs a full sequence.

Source files
------------

// File: rtl/dec_sel_sequencer_if.sv
// Bundle of control, configuration and decoder feedback signals
// between a controller (master) and the select sequencer (slave).
interface dec_sel_sequencer_if #(
  parameter int DW = 4,
  parameter int NW = 4
);
  logic          start;
  logic          stop;
  logic [DW-1:0] dwell;
  logic [NW-1:0] periods;
  logic [1:0]    dec_y;
  logic          sel;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output start, stop, dwell, periods, dec_y,
    input  sel, busy, done, err
  );

  modport slave (
    input  start, stop, dwell, periods, dec_y,
    output sel, busy, done, err
  );
endinterface

// File: rtl/dec_sel_sequencer.sv
// Alternating 0/1 select sequencer for a 1-to-2 decoder with
// per-phase dwell, period count, abort and one-hot feedback check.
module dec_sel_sequencer #(
  parameter int DW = 4,
  parameter int NW = 4
) (
  input logic               clk,
  input logic               rst,
  dec_sel_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL0 = 2'd1,
    SEL1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [NW-1:0] per_q, per_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    exp_y;

  // Next-state, counter, latch and error-flag logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    per_d   = per_q;
    err_d   = err_q;
    exp_y   = sel_q ? 2'b10 : 2'b01;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = SEL0;
          dwell_d = bus.dwell;
          per_d   = bus.periods;
          cnt_d   = bus.dwell;
          err_d   = 1'b0;
        end
      end
      SEL0: begin
        if (bus.dec_y != exp_y) err_d = 1'b1;
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = SEL1;
          cnt_d   = dwell_q;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      SEL1: begin
        if (bus.dec_y != exp_y) err_d = 1'b1;
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (per_q != '0) begin
            state_d = SEL0;
            per_d   = per_q - NW'(1);
            cnt_d   = dwell_q;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs follow the upcoming state.
  always_comb begin
    sel_d  = (state_d == SEL1);
    busy_d = (state_d == SEL0) || (state_d == SEL1);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dwell_q <= '0;
      per_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      per_q   <= per_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Directed scoreboard bench for dec_sel_sequencer.
// Expected {sel,busy,done,err} vectors are queued then checked.
module tb_dec_sel_sequencer;

  logic clk;
  logic clk_en;
  logic rst;
  logic inj;
  int   nvec;
  int   nerr;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  dec_sel_sequencer_if #(.DW(4), .NW(4)) bus ();

  dec_sel_sequencer #(.DW(4), .NW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model of the downstream decoder, with a fault injector.
  assign bus.dec_y = inj ? 2'b11 : (bus.sel ? 2'b10 : 2'b01);

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic push(string tag, logic s, logic b, logic d, logic e);
    exp_q.push_back({s, b, d, e});
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    logic [3:0] ev;
    logic [3:0] ov;
    string      t;
    ev = exp_q.pop_front();
    t  = tag_q.pop_front();
    ov = {bus.sel, bus.busy, bus.done, bus.err};
    nvec++;
    assert (ov === ev) else begin
      nerr++;
      $error("FAIL %s: observed sel/busy/done/err=%b expected %b",
             t, ov, ev);
    end
  endtask

  task automatic chk_now(string tag, logic s, logic b,
                         logic d, logic e);
    push(tag, s, b, d, e);
    pop_cmp();
  endtask

  task automatic tick(string tag, logic s, logic b, logic d, logic e);
    push(tag, s, b, d, e);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  // Start is held for the first cycle only; inputs are then
  // scrambled to show the configuration was latched.
  task automatic run_full(string tag, int d, int p);
    bus.dwell   = 4'(d);
    bus.periods = 4'(p);
    bus.start   = 1'b1;
    for (int i = 0; i <= p; i++) begin
      for (int k = 0; k <= d; k++) begin
        tick(tag, 1'b0, 1'b1, 1'b0, 1'b0);
        if (bus.start) begin
          bus.start   = 1'b0;
          bus.dwell   = 4'(~d);
          bus.periods = 4'(~p);
        end
      end
      for (int k = 0; k <= d; k++)
        tick(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0);
    tick({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nvec        = 0;
    nerr        = 0;
    clk_en      = 1'b0;
    rst         = 1'b0;
    inj         = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.dwell   = '0;
    bus.periods = '0;

    // Reset with no clock running.
    #2 rst = 1'b1;
    #3 chk_now("rst_noclk", 1'b0, 1'b0, 1'b0, 1'b0);
    clk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    tick("idle_after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // dwell=2, periods=1: 12 busy cycles then done.
    run_full("d2p1", 2, 1);

    // dwell=0, periods=0 with start held during busy and DONE.
    bus.dwell   = 4'd0;
    bus.periods = 4'd0;
    bus.start   = 1'b1;
    tick("d0p0_sel0", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("d0p0_sel1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick("d0p0_done", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    tick("d0p0_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE: stop wins.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick("startstop_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("startstop_idle2", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Abort in the 2nd SEL1 cycle with dwell=3.
    bus.dwell   = 4'd3;
    bus.periods = 4'd0;
    bus.start   = 1'b1;
    tick("stop_sel0", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++)
      tick("stop_sel0", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("stop_sel1a", 1'b1, 1'b1, 1'b0, 1'b0);
    tick("stop_sel1b", 1'b1, 1'b1, 1'b0, 1'b0);
    bus.stop = 1'b1;
    tick("stop_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.stop = 1'b0;
    for (int k = 0; k < 3; k++)
      tick("stop_nodone", 1'b0, 1'b0, 1'b0, 1'b0);

    // Decoder feedback fault in one SEL1 cycle.
    bus.dwell   = 4'd1;
    bus.periods = 4'd0;
    bus.start   = 1'b1;
    tick("err_sel0", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("err_sel0b", 1'b0, 1'b1, 1'b0, 1'b0);
    tick("err_sel1a", 1'b1, 1'b1, 1'b0, 1'b0);
    inj = 1'b1;
    tick("err_set", 1'b1, 1'b1, 1'b0, 1'b1);
    inj = 1'b0;
    tick("err_done", 1'b0, 1'b0, 1'b1, 1'b1);
    tick("err_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    tick("err_idle2", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.dwell   = 4'd0;
    bus.periods = 4'd0;
    bus.start   = 1'b1;
    tick("err_clear", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("err_clr_sel1", 1'b1, 1'b1, 1'b0, 1'b0);
    tick("err_clr_done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick("err_clr_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset between edges mid-SEL0.
    bus.dwell   = 4'd3;
    bus.periods = 4'd2;
    bus.start   = 1'b1;
    tick("rst_sel0", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    tick("rst_sel0b", 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_now("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick("rst_rel_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("rst_rel_idle2", 1'b0, 1'b0, 1'b0, 1'b0);
    run_full("after_rst", 1, 1);

    if (exp_q.size() != 0) begin
      nerr++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0",
             exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
